// File: rtl/tanimoto_pkg.sv
// tanimoto_pkg: derived widths and lane slicing shared by the Tanimoto comparator array
package tanimoto_pkg;
  function automatic int cnt_w(input int vw);
    return $clog2(vw + 1);
  endfunction
  function automatic int sum_w(input int vw);
    return $clog2(vw + 1) + 1;
  endfunction
  function automatic int depth_of(input int vw);
    return 2 * vw + 1;
  endfunction
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/tanimoto_thr_bank.sv
// tanimoto_thr_bank: double-buffered threshold table, writes hit the shadow bank, reads the active one
module tanimoto_thr_bank import tanimoto_pkg::*; #(
  parameter int VECTOR_WIDTH = 35,
  localparam int CNT_WIDTH = cnt_w(VECTOR_WIDTH),
  localparam int SUM_WIDTH = sum_w(VECTOR_WIDTH),
  localparam int DEPTH = depth_of(VECTOR_WIDTH)
) (
  input  logic                 clk,
  input  logic                 sel,
  input  logic                 we,
  input  logic [SUM_WIDTH-1:0] wr_addr,
  input  logic [CNT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [SUM_WIDTH-1:0] rd_addr,
  output logic [CNT_WIDTH-1:0] rd_data
);
  logic [CNT_WIDTH-1:0] bank0 [DEPTH];
  logic [CNT_WIDTH-1:0] bank1 [DEPTH];
  // shadow write uses the pre-swap select so a write alongside a commit becomes active
  always_ff @(posedge clk) begin
    if (we && sel) bank0[wr_addr] <= wr_data;
    if (we && !sel) bank1[wr_addr] <= wr_data;
    if (rd_en) rd_data <= sel ? bank1[rd_addr] : bank0[rd_addr];
  end
endmodule

// File: rtl/tanimoto_comparator_array.sv
// tanimoto_comparator_array: multi-lane C >= T[A+B] comparator with double-buffered thresholds
module tanimoto_comparator_array import tanimoto_pkg::*; #(
  parameter int VECTOR_WIDTH = 35,
  parameter int NUM_LANES = 4,
  parameter int ID_WIDTH = 16,
  localparam int CNT_WIDTH = cnt_w(VECTOR_WIDTH),
  localparam int SUM_WIDTH = sum_w(VECTOR_WIDTH),
  localparam int DEPTH = depth_of(VECTOR_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES*CNT_WIDTH-1:0] i_CntA,
  input  logic [NUM_LANES*CNT_WIDTH-1:0] i_CntB,
  input  logic [NUM_LANES*CNT_WIDTH-1:0] i_CntC,
  input  logic [ID_WIDTH-1:0]            i_Id,
  input  logic                           i_Valid,
  output logic                           o_Ready,
  input  logic                           i_ThrWrEn,
  input  logic [CNT_WIDTH-1:0]           i_Threshold,
  input  logic                           i_ThrCommit,
  output logic                           o_ThrFull,
  output logic                           o_TableValid,
  output logic                           o_Valid,
  input  logic                           i_Ready,
  output logic [NUM_LANES-1:0]           o_Dout,
  output logic [ID_WIDTH-1:0]            o_Id,
  output logic                           o_Err
);
  localparam int LW = NUM_LANES * CNT_WIDTH;
  localparam logic [SUM_WIDTH-1:0] LAST = SUM_WIDTH'(DEPTH - 1);
  logic en, sel, s1_valid, s2_valid;
  logic [SUM_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] s1_id, s2_id;
  logic [LW-1:0] s1_a, s1_b, s1_c, s2_c;
  logic [NUM_LANES-1:0] bad, s2_bad, hit;
  assign en = ~o_Valid | i_Ready;
  assign o_Ready = en;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [CNT_WIDTH-1:0] a, b, c, c2, t;
    logic [SUM_WIDTH-1:0] sum, idx;
    assign a = s1_a[lane_lo(k, CNT_WIDTH) +: CNT_WIDTH];
    assign b = s1_b[lane_lo(k, CNT_WIDTH) +: CNT_WIDTH];
    assign c = s1_c[lane_lo(k, CNT_WIDTH) +: CNT_WIDTH];
    assign c2 = s2_c[lane_lo(k, CNT_WIDTH) +: CNT_WIDTH];
    assign sum = SUM_WIDTH'(a) + SUM_WIDTH'(b);
    assign idx = sum > LAST ? LAST : sum;
    assign bad[k] = c > (a < b ? a : b);
    assign hit[k] = ~s2_bad[k] & o_TableValid & (c2 >= t);
    tanimoto_thr_bank #(.VECTOR_WIDTH(VECTOR_WIDTH)) u_bank (
      .clk(clk),
      .sel(sel),
      .we(i_ThrWrEn & ~rst),
      .wr_addr(ptr),
      .wr_data(i_Threshold),
      .rd_en(en),
      .rd_addr(idx),
      .rd_data(t)
    );
  end
  // three-stage pipeline: capture counts, read threshold, compare into output register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      o_Valid <= 1'b0;
      o_Dout <= '0;
      o_Id <= '0;
      o_Err <= 1'b0;
    end else if (en) begin
      s1_valid <= i_Valid;
      s1_id <= i_Id;
      s1_a <= i_CntA;
      s1_b <= i_CntB;
      s1_c <= i_CntC;
      s2_valid <= s1_valid;
      s2_id <= s1_id;
      s2_c <= s1_c;
      s2_bad <= bad;
      o_Valid <= s2_valid;
      o_Id <= s2_id;
      o_Dout <= hit;
      o_Err <= o_Err | (s2_valid & |s2_bad);
    end
  end
  // table fill pointer and bank swap run independently of pipeline stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      o_ThrFull <= 1'b0;
      sel <= 1'b0;
      o_TableValid <= 1'b0;
    end else if (i_ThrCommit) begin
      ptr <= '0;
      o_ThrFull <= 1'b0;
      sel <= ~sel;
      o_TableValid <= 1'b1;
    end else if (i_ThrWrEn) begin
      ptr <= ptr == LAST ? '0 : ptr + SUM_WIDTH'(1);
      o_ThrFull <= o_ThrFull | (ptr == LAST);
    end
  end
endmodule
